// File: rtl/rob_multi_pkg.sv
// Shared encodings for the multi-port reorder buffer: op kinds, commit FSM
// states, store size codes and the default datapath width.
package rob_multi_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] MEM_SIZE_B = 3'd1;
  localparam logic [2:0] MEM_SIZE_H = 3'd2;
  localparam logic [2:0] MEM_SIZE_W = 3'd4;

endpackage

// File: rtl/rob_wb_merge.sv
// Resolves WB_PORTS writebacks into per-entry write enables and data;
// only tags inside the occupied window count, and the lowest port wins.
module rob_wb_merge #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]                 head_idx,
  input  logic [TAG_W:0]                   count,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]        wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_value,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_aux,
  output logic [DEPTH-1:0]                 ent_we,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_value,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_aux
);

  logic [WB_PORTS-1:0] port_hit;
  logic [TAG_W-1:0]    port_tag [WB_PORTS];
  logic [TAG_W-1:0]    port_off [WB_PORTS];

  always_comb begin
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      port_tag[p] = wb_tag[p*TAG_W +: TAG_W];
      port_off[p] = port_tag[p] - head_idx;
      port_hit[p] = wb_valid[p] && ({1'b0, port_off[p]} < count);
    end
  end

  // Ports are scanned from highest to lowest so the lowest index lands last.
  always_comb begin
    ent_we    = '0;
    ent_value = '0;
    ent_aux   = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      for (int unsigned k = WB_PORTS; k > 0; k--) begin
        if (port_hit[k-1] && port_tag[k-1] == TAG_W'(e)) begin
          ent_we[e]    = 1'b1;
          ent_value[e] = wb_value[(k-1)*DATA_W +: DATA_W];
          ent_aux[e]   = wb_aux[(k-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// In-order reorder buffer with multiple writeback ports, branch/JALR redirect,
// and a blocking store handshake at the head.
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  localparam int unsigned TAG_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [1:0]                   alloc_kind,
  input  logic [4:0]                   alloc_rd,
  input  logic [DATA_W-1:0]            alloc_pc,
  input  logic                         alloc_pred,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_aux,
  output logic                         cm_valid,
  output logic [TAG_W-1:0]             cm_tag,
  output logic [4:0]                   cm_rd,
  output logic [DATA_W-1:0]            cm_value,
  output logic                         mem_req,
  output logic [DATA_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  output logic [2:0]                   mem_size,
  input  logic                         mem_done,
  output logic                         bp_valid,
  output logic                         bp_taken,
  output logic [DATA_W-1:0]            bp_pc,
  output logic                         flush,
  output logic [DATA_W-1:0]            flush_pc,
  output logic [TAG_W:0]               count
);

  kind_e             ent_kind  [DEPTH];
  logic [4:0]        ent_rd    [DEPTH];
  logic [DATA_W-1:0] ent_pc    [DEPTH];
  logic              ent_pred  [DEPTH];
  logic [DATA_W-1:0] ent_value [DEPTH];
  logic [DATA_W-1:0] ent_aux   [DEPTH];
  logic [DEPTH-1:0]  ent_ready;

  logic [TAG_W:0]    head_ptr, tail_ptr;
  logic [TAG_W-1:0]  head_idx, tail_idx;
  state_e            state, state_nxt;
  logic              alloc_fire, head_adv;

  logic              cm_valid_q, cm_valid_n;
  logic [TAG_W-1:0]  cm_tag_q, cm_tag_n;
  logic [4:0]        cm_rd_q, cm_rd_n;
  logic [DATA_W-1:0] cm_value_q, cm_value_n;
  logic              bp_valid_q, bp_valid_n, bp_taken_q, bp_taken_n;
  logic [DATA_W-1:0] bp_pc_q, bp_pc_n;
  logic              flush_q, flush_n;
  logic [DATA_W-1:0] flush_pc_q, flush_pc_n;
  logic              mem_req_q, mem_req_n;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_n, mem_data_q, mem_data_n;
  logic [2:0]        mem_size_q, mem_size_n;

  logic [DEPTH-1:0]              wb_we;
  logic [DEPTH-1:0][DATA_W-1:0]  wb_ent_value, wb_ent_aux;

  kind_e             h_kind;
  logic [DATA_W-1:0] h_value, h_aux, h_pc;

  assign head_idx    = head_ptr[TAG_W-1:0];
  assign tail_idx    = tail_ptr[TAG_W-1:0];
  assign count       = tail_ptr - head_ptr;
  assign alloc_ready = !count[TAG_W] && !flush_q;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready && rdy;

  assign h_kind  = ent_kind[head_idx];
  assign h_value = ent_value[head_idx];
  assign h_aux   = ent_aux[head_idx];
  assign h_pc    = ent_pc[head_idx];

  rob_wb_merge #(
    .DEPTH    (DEPTH),
    .WB_PORTS (WB_PORTS),
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W)
  ) u_wb_merge (
    .head_idx  (head_idx),
    .count     (count),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_value  (wb_value),
    .wb_aux    (wb_aux),
    .ent_we    (wb_we),
    .ent_value (wb_ent_value),
    .ent_aux   (wb_ent_aux)
  );

  always_comb begin
    state_nxt  = state;
    head_adv   = 1'b0;
    cm_valid_n = 1'b0;
    cm_tag_n   = cm_tag_q;
    cm_rd_n    = cm_rd_q;
    cm_value_n = cm_value_q;
    bp_valid_n = 1'b0;
    bp_taken_n = bp_taken_q;
    bp_pc_n    = bp_pc_q;
    flush_n    = 1'b0;
    flush_pc_n = flush_pc_q;
    mem_req_n  = 1'b0;
    mem_addr_n = mem_addr_q;
    mem_data_n = mem_data_q;
    mem_size_n = mem_size_q;
    case (state)
      ST_IDLE: begin
        if (!flush_q && count != '0 && ent_ready[head_idx]) begin
          cm_tag_n   = head_idx;
          cm_value_n = h_value;
          case (h_kind)
            KIND_REG: begin
              cm_valid_n = 1'b1;
              cm_rd_n    = ent_rd[head_idx];
              head_adv   = 1'b1;
            end
            KIND_BRANCH: begin
              cm_valid_n = 1'b1;
              cm_rd_n    = '0;
              bp_valid_n = 1'b1;
              bp_taken_n = h_value[0];
              bp_pc_n    = h_pc;
              head_adv   = 1'b1;
              if (h_value[0] != ent_pred[head_idx]) begin
                flush_n    = 1'b1;
                flush_pc_n = h_value[0] ? h_aux : h_pc + DATA_W'(4);
              end
            end
            KIND_JALR: begin
              cm_valid_n = 1'b1;
              cm_rd_n    = ent_rd[head_idx];
              flush_n    = 1'b1;
              flush_pc_n = h_aux;
              head_adv   = 1'b1;
            end
            KIND_STORE: begin
              state_nxt  = ST_MEM_WAIT;
              mem_req_n  = 1'b1;
              mem_addr_n = h_aux;
              mem_data_n = h_value;
              mem_size_n = MEM_SIZE_W;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        if (mem_done) begin
          state_nxt  = ST_IDLE;
          cm_valid_n = 1'b1;
          cm_tag_n   = head_idx;
          cm_rd_n    = '0;
          cm_value_n = h_value;
          head_adv   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      state      <= ST_IDLE;
      ent_ready  <= '0;
      cm_valid_q <= 1'b0;
      cm_tag_q   <= '0;
      cm_rd_q    <= '0;
      cm_value_q <= '0;
      bp_valid_q <= 1'b0;
      bp_taken_q <= 1'b0;
      bp_pc_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_size_q <= '0;
    end else if (rdy) begin
      cm_valid_q <= cm_valid_n;
      cm_tag_q   <= cm_tag_n;
      cm_rd_q    <= cm_rd_n;
      cm_value_q <= cm_value_n;
      bp_valid_q <= bp_valid_n;
      bp_taken_q <= bp_taken_n;
      bp_pc_q    <= bp_pc_n;
      flush_q    <= flush_n;
      flush_pc_q <= flush_pc_n;
      mem_req_q  <= mem_req_n;
      mem_addr_q <= mem_addr_n;
      mem_data_q <= mem_data_n;
      mem_size_q <= mem_size_n;
      if (flush_q) begin
        head_ptr  <= '0;
        tail_ptr  <= '0;
        ent_ready <= '0;
        state     <= ST_IDLE;
      end else begin
        state <= state_nxt;
        if (head_adv) head_ptr <= head_ptr + (TAG_W+1)'(1);
        for (int unsigned e = 0; e < DEPTH; e++)
          if (wb_we[e]) ent_ready[e] <= 1'b1;
        // Allocation clears last; writebacks can never target the tail slot.
        if (alloc_fire) begin
          ent_ready[tail_idx] <= 1'b0;
          tail_ptr            <= tail_ptr + (TAG_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush_q) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wb_we[e]) begin
          ent_value[e] <= wb_ent_value[e];
          ent_aux[e]   <= wb_ent_aux[e];
        end
      end
      if (alloc_fire) begin
        ent_kind[tail_idx] <= kind_e'(alloc_kind);
        ent_rd[tail_idx]   <= alloc_rd;
        ent_pc[tail_idx]   <= alloc_pc;
        ent_pred[tail_idx] <= alloc_pred;
      end
    end
  end

  // Pulses freeze with the rest of the state but are hidden while stalled.
  assign cm_valid = cm_valid_q && rdy;
  assign bp_valid = bp_valid_q && rdy;
  assign flush    = flush_q && rdy;
  assign mem_req  = mem_req_q && rdy;
  assign cm_tag   = cm_tag_q;
  assign cm_rd    = cm_rd_q;
  assign cm_value = cm_value_q;
  assign bp_taken = bp_taken_q;
  assign bp_pc    = bp_pc_q;
  assign flush_pc = flush_pc_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_size = mem_size_q;

endmodule

// File: tb/tb_rob_multi.sv
// Randomized and directed bench for rob_multi against a queue-based model;
// a second DEPTH=4 instance exercises pointer wrap.
module tb_rob_multi;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, alloc_valid, alloc_pred, mem_done;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [1:0]  alloc_kind;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_tag;
  logic [63:0] wb_value, wb_aux;
  logic        cm_valid, mem_req, bp_valid, bp_taken, flush;
  logic [3:0]  cm_tag;
  logic [4:0]  cm_rd;
  logic [31:0] cm_value, mem_addr, mem_data, bp_pc, flush_pc;
  logic [2:0]  mem_size;
  logic [4:0]  count;

  logic        alloc_valid4, alloc_ready4;
  logic [1:0]  alloc_tag4, wb_valid4;
  logic [3:0]  wb_tag4;
  logic [63:0] wb_value4, wb_aux4;
  logic        cm_valid4, mem_req4, bp_valid4, bp_taken4, flush4;
  logic [1:0]  cm_tag4;
  logic [4:0]  cm_rd4;
  logic [31:0] cm_value4, mem_addr4, mem_data4, bp_pc4, flush_pc4;
  logic [2:0]  mem_size4, count4;

  always #5 clk = ~clk;

  rob_multi #(.DEPTH(16), .WB_PORTS(2), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_aux(wb_aux),
    .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_value(cm_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_done(mem_done), .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_pc(bp_pc),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  rob_multi #(.DEPTH(4), .WB_PORTS(2), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid4), .alloc_ready(alloc_ready4), .alloc_tag(alloc_tag4),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .wb_valid(wb_valid4), .wb_tag(wb_tag4), .wb_value(wb_value4), .wb_aux(wb_aux4),
    .cm_valid(cm_valid4), .cm_tag(cm_tag4), .cm_rd(cm_rd4), .cm_value(cm_value4),
    .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_data(mem_data4), .mem_size(mem_size4),
    .mem_done(1'b0), .bp_valid(bp_valid4), .bp_taken(bp_taken4), .bp_pc(bp_pc4),
    .flush(flush4), .flush_pc(flush_pc4), .count(count4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: program-order queue of in-flight ops, oldest first.
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] value;
    logic [31:0] aux;
    bit          ready;
  } ent_t;

  ent_t        mq[$];
  int          m_head = 0;
  bit          m_wait = 0;
  bit          e_cm = 0, e_bp = 0, e_fl = 0, e_mem = 0, e_bp_taken = 0;
  int          e_cm_tag = 0;
  logic [4:0]  e_cm_rd = '0;
  logic [31:0] e_cm_val = '0, e_bp_pc = '0, e_fl_pc = '0, e_mem_addr = '0, e_mem_data = '0;

  task automatic model_edge();
    ent_t h, t;
    int   n, off;
    bit   pop, nf;
    if (rst) begin
      mq.delete(); m_head = 0; m_wait = 0;
      e_cm = 0; e_bp = 0; e_fl = 0; e_mem = 0;
      return;
    end
    if (!rdy) return;
    e_cm = 0; e_bp = 0; e_mem = 0;
    if (e_fl) begin
      mq.delete(); m_head = 0; m_wait = 0; e_fl = 0;
      return;
    end
    n = mq.size(); pop = 0; nf = 0;
    if (!m_wait && n > 0 && mq[0].ready) begin
      h = mq[0];
      e_cm_tag = m_head; e_cm_val = h.value;
      case (h.kind)
        2'd0: begin e_cm = 1; e_cm_rd = h.rd; pop = 1; end
        2'd1: begin
          e_cm = 1; e_cm_rd = 0; pop = 1;
          e_bp = 1; e_bp_taken = h.value[0]; e_bp_pc = h.pc;
          if (h.value[0] != h.pred) begin nf = 1; e_fl_pc = h.value[0] ? h.aux : h.pc + 4; end
        end
        2'd2: begin m_wait = 1; e_mem = 1; e_mem_addr = h.aux; e_mem_data = h.value; end
        default: begin e_cm = 1; e_cm_rd = h.rd; nf = 1; e_fl_pc = h.aux; pop = 1; end
      endcase
    end else if (m_wait && mem_done) begin
      e_cm = 1; e_cm_tag = m_head; e_cm_rd = 0; e_cm_val = mq[0].value; pop = 1; m_wait = 0;
    end
    for (int p = 1; p >= 0; p--) begin
      if (wb_valid[p]) begin
        off = (int'(wb_tag[p*4 +: 4]) - m_head + D) % D;
        if (off < n) begin
          t = mq[off];
          t.value = wb_value[p*32 +: 32]; t.aux = wb_aux[p*32 +: 32]; t.ready = 1;
          mq[off] = t;
        end
      end
    end
    if (pop) begin void'(mq.pop_front()); m_head = (m_head + 1) % D; end
    if (alloc_valid && n < D) begin
      t.kind = alloc_kind; t.rd = alloc_rd; t.pc = alloc_pc; t.pred = alloc_pred;
      t.value = 0; t.aux = 0; t.ready = 0;
      mq.push_back(t);
    end
    e_fl = nf;
  endtask

  task automatic step();
    if (!rst) begin
      check("alloc_ready", alloc_ready, (mq.size() < D) && !e_fl);
      if (alloc_ready) check("alloc_tag", alloc_tag, (m_head + mq.size()) % D);
    end
    model_edge();
    @(posedge clk);
    #1;
    check("count", count, mq.size());
    check("cm_valid", cm_valid, e_cm && rdy);
    if (cm_valid && e_cm) begin
      check("cm_tag", cm_tag, e_cm_tag);
      check("cm_rd", cm_rd, e_cm_rd);
      check("cm_value", cm_value, e_cm_val);
    end
    check("bp_valid", bp_valid, e_bp && rdy);
    if (bp_valid && e_bp) begin
      check("bp_taken", bp_taken, e_bp_taken);
      check("bp_pc", bp_pc, e_bp_pc);
    end
    check("flush", flush, e_fl && rdy);
    if (flush && e_fl) check("flush_pc", flush_pc, e_fl_pc);
    check("mem_req", mem_req, e_mem && rdy);
    if (mem_req && e_mem) begin
      check("mem_addr", mem_addr, e_mem_addr);
      check("mem_data", mem_data, e_mem_data);
      check("mem_size", mem_size, 3'd4);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; wb_valid = '0; mem_done = 0; alloc_valid4 = 0; wb_valid4 = '0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] val, input logic [31:0] aux);
    wb_valid[p] = 1'b1;
    wb_tag[p*4 +: 4] = 4'(tag);
    wb_value[p*32 +: 32] = val;
    wb_aux[p*32 +: 32] = aux;
  endtask

  task automatic do_reset();
    idle_inputs(); rdy = 1; rst = 1;
    step();
    rst = 0;
    check("rst_cm_value", cm_value, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_bp_pc", bp_pc, 0);
    check("rst_count4", count4, 0);
  endtask

  task automatic store_to_wait();
    alloc_kind = 2'd2; alloc_pc = 32'h40; alloc_valid = 1;
    step();
    alloc_valid = 0; set_wb(0, 0, 32'h55, 32'h2000);
    step();
    wb_valid = '0;
    step();
    check("st_mem_req", mem_req, 1);
    check("st_mem_addr", mem_addr, 32'h2000);
    check("st_mem_data", mem_data, 32'h55);
    check("st_mem_size", mem_size, 3'd4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, w, c, cyc;
    bit fire, wdone, seen;
    rst = 1; rdy = 1; alloc_kind = 0; alloc_rd = 0; alloc_pc = 0; alloc_pred = 0;
    wb_tag = '0; wb_value = '0; wb_aux = '0; wb_tag4 = '0; wb_value4 = '0; wb_aux4 = '0;
    idle_inputs();
    #1;

    // Fill to full, then one commit frees a slot.
    do_reset();
    alloc_kind = 2'd0; alloc_rd = 5'd5; alloc_valid = 1;
    repeat (16) step();
    check("full_ready", alloc_ready, 0);
    check("full_count", count, 16);
    step();
    alloc_valid = 0; set_wb(0, 0, 32'h11, 32'h0);
    step();
    wb_valid = '0;
    step();
    check("freed_ready", alloc_ready, 1);

    // Two ports hit tag 3 in one cycle: port 0 wins.
    do_reset();
    alloc_rd = 5'd7; alloc_valid = 1;
    repeat (4) step();
    alloc_valid = 0; set_wb(0, 3, 32'hA, 0); set_wb(1, 3, 32'hB, 0);
    step();
    set_wb(0, 0, 32'h1, 0); set_wb(1, 1, 32'h2, 0);
    step();
    wb_valid = '0; set_wb(0, 2, 32'h3, 0);
    step();
    wb_valid = '0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cm_valid && cm_tag == 4'd3) begin check("dup_wb_value", cm_value, 32'hA); seen = 1; end
    end
    check("dup_wb_seen", seen, 1);

    // Mispredicted branch redirects to pc+4 and empties the buffer.
    do_reset();
    alloc_kind = 2'd1; alloc_pred = 1; alloc_pc = 32'h100; alloc_valid = 1;
    step();
    alloc_valid = 0; set_wb(0, 0, 32'h0, 32'h200);
    step();
    wb_valid = '0;
    step();
    check("br_bp_valid", bp_valid, 1);
    check("br_bp_taken", bp_taken, 0);
    check("br_flush", flush, 1);
    check("br_flush_pc", flush_pc, 32'h104);
    step();
    check("br_count", count, 0);

    // Store waits for mem_done before retiring.
    do_reset();
    store_to_wait();
    step();
    check("st_req_pulse", mem_req, 0);
    repeat (4) step();
    mem_done = 1;
    step();
    mem_done = 0;
    check("st_cm_valid", cm_valid, 1);
    check("st_cm_rd", cm_rd, 0);
    check("st_count", count, 0);

    // Reset while waiting abandons the store.
    do_reset();
    store_to_wait();
    rst = 1;
    step();
    rst = 0;
    check("rw_count", count, 0);
    check("rw_mem_req", mem_req, 0);
    mem_done = 1;
    step();
    mem_done = 0;
    check("rw_cm_valid", cm_valid, 0);
    step();
    check("rw_no_req", mem_req, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      alloc_valid = $urandom_range(0, 1);
      alloc_kind = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      alloc_rd = 5'($urandom); alloc_pc = $urandom & 32'hFFFF_FFFC; alloc_pred = $urandom_range(0, 1);
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] = ($urandom_range(0, 2) != 0);
        wb_tag[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                         : 4'((m_head + $urandom_range(0, mq.size())) % D);
        wb_value[p*32 +: 32] = $urandom; wb_aux[p*32 +: 32] = $urandom;
      end
      mem_done = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      step();
    end

    // DEPTH=4 wrap: 40 ops, tags cycle 0..3, commits in order.
    do_reset();
    alloc_kind = 2'd0; alloc_rd = 5'd3;
    a = 0; w = 0; c = 0; cyc = 0;
    while (c < 40 && cyc < 600) begin
      alloc_valid4 = (a < 40);
      fire = alloc_valid4 && alloc_ready4;
      if (fire) check("wrap_tag", alloc_tag4, a % 4);
      wb_valid4 = '0; wdone = 0;
      if (w < a && $urandom_range(0, 1) == 1) begin
        wb_valid4[0] = 1; wb_tag4[1:0] = 2'(w % 4); wb_value4[31:0] = w; wdone = 1;
      end
      step();
      if (fire) a++;
      if (wdone) w++;
      if (cm_valid4) begin
        check("wrap_cm_tag", cm_tag4, c % 4);
        check("wrap_cm_value", cm_value4, c);
        c++;
      end
      check("wrap_occ", count4, a - c);
      check("wrap_bound", count4 <= 4, 1);
      cyc++;
    end
    check("wrap_commits", c, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
